tcalc_arb: RTL and testbench
============================

TCALC_ARB -- requirements
Module: tcalc_arb

Interface
REQ-001 SHALL have parameter DP_LAT, default 6: cycles from dp_in_valid to the matching dp_out_valid of the shared transmission datapath.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2: result FIFO depth per requester.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports:
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous active-high reset
  start  in  1  pulse, IDLE->RUN
  stop  in  1  pulse, begin drain
  busy  out  1  high in RUN or DRAIN
  err_orphan  out  1  sticky: dp result arrived with no tag
  rK_valid / rK_ready  in / out  1 each  request handshake, K=0,1
  rK_sh, rK_sd, rK_k  in  12 each  S_H Q12, S_D Q12, K Q4.8
  oK_valid / oK_ready  out / in  1 each  result handshake, K=0,1
  oK_inv_t  out  12  inv_t Q4.8
  dp_in_valid  out  1  datapath issue strobe
  dp_sh, dp_sd, dp_k  out  12 each  datapath operands
  dp_out_valid  in  1  datapath result strobe
  dp_inv_t  in  12  datapath result

Function
REQ-005 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on stop; DRAIN->IDLE when in-flight count = 0 and both FIFOs empty; stop wins over start in the same cycle; start is ignored in RUN and DRAIN.
REQ-006 rK_ready SHALL be high only in RUN, when credit[K] > 0 and K holds the grant; it may depend on the other port's valid, never on its own.
REQ-007 credit[K] SHALL equal FIFO_DEPTH minus FIFO K occupancy minus in-flight tags of K, so the FIFO never overflows.
REQ-008 Arbitration SHALL be round-robin: with both eligible, grant the port not granted last; a single eligible port always wins; the last-granted pointer updates only on an accepted transfer.
REQ-009 An accept at edge N SHALL register operands to dp_* with dp_in_valid=1 in cycle N+1; at most one issue per cycle; dp_* operands hold the last value when dp_in_valid=0.
REQ-010 A DP_LAT-deep shift register of {valid, id} SHALL tag each issue; dp_out_valid writes dp_inv_t into the FIFO named by the tag at the shift-register tail.
REQ-011 dp_out_valid with an invalid tail slot SHALL set err_orphan (cleared only by rst) and discard the data.
REQ-012 oK_valid SHALL assert the cycle after the FIFO write; results are returned in issue order per port; a pop occurs on oK_valid && oK_ready.
REQ-013 A simultaneous push and pop on a full FIFO SHALL keep occupancy unchanged and lose no data.
REQ-014 End-to-end minimum latency, accept to oK_valid, SHALL be DP_LAT+2 cycles.

Reset
REQ-015 rst SHALL clear: FSM to IDLE, busy=0, all ready/valid outputs=0, dp_in_valid=0, dp_* operands=0, tags, FIFOs, pointers, counters and err_orphan.
REQ-016 rst mid-operation SHALL drop in-flight results; integration ties datapath reset to rst so both sides clear on the same edge.

Configuration
REQ-017 Macro TCALC_ARB_STATS_EN SHALL add outputs stat_issue0 and stat_issue1 (16-bit saturating accept counts) and stat_stall (16-bit saturating count of cycles with rK_valid=1 and rK_ready=0 in RUN).
REQ-018 Without TCALC_ARB_STATS_EN these ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-019 Package tcalc_pkg SHALL hold the 12-bit width constant, the DP_LAT default, the FSM state enum and the request struct {sh, sd, k}.
REQ-020 The per-port result FIFO SHALL be sub-module tcalc_res_fifo, instantiated twice.

Verification
REQ-021 Single request (r0: sh=0x400, sd=0x800, k=0x140) after start -> dp_in_valid 1 cycle after accept; o0_valid at accept+8 with golden-model inv_t.
REQ-022 Both ports valid continuously, outputs always ready -> accepts alternate 0,1,0,1; 100 results per port, each in order and matching the model.
REQ-023 o0_ready held low, r0 valid continuously -> exactly 4 accepts on port 0, then r0_ready stays 0; port 1 keeps flowing; releasing o0_ready resumes port 0 with no loss.
REQ-024 stop asserted with 3 requests in flight -> no further accepts, busy stays 1 until all 3 results are popped, then IDLE and busy=0.
REQ-025 dp_out_valid injected with no issue outstanding -> err_orphan=1 and held until rst; no FIFO write.
REQ-026 rst asserted 2 cycles after an accept -> all outputs 0 the next cycle, and no stale result appears after restart.

Source files
------------

// File: rtl/tcalc_pkg.sv
// Shared width, latency default, FSM states and request operand bundle for the tcalc arbiter.
package tcalc_pkg;

  localparam int unsigned W            = 12;
  localparam int unsigned DpLatDefault = 6;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  typedef struct packed {
    logic [W-1:0] sh;
    logic [W-1:0] sd;
    logic [W-1:0] k;
  } req_t;

endpackage

// File: rtl/tcalc_res_fifo.sv
// Per-port result FIFO; power-of-two depth, occupancy exported for credit accounting.
module tcalc_res_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   empty_o
);

  localparam int unsigned AW      = $clog2(Depth);
  localparam logic [AW:0] FullCnt = (AW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  // A full FIFO still takes a push when the same cycle pops.
  assign do_push = push_i && ((cnt_q != FullCnt) || do_pop);

  always_comb begin
    wptr_d = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = do_pop ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_push) mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/tcalc_arb.sv
// Two-port round-robin front end for the shared tcalc datapath with per-port result FIFOs.
// Define TCALC_ARB_STATS_EN to add saturating accept and stall counters.
module tcalc_arb
  import tcalc_pkg::*;
#(
  parameter int unsigned DP_LAT     = DpLatDefault,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  output logic         busy,
  output logic         err_orphan,
`ifdef TCALC_ARB_STATS_EN
  output logic [15:0]  stat_issue0,
  output logic [15:0]  stat_issue1,
  output logic [15:0]  stat_stall,
`endif
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [W-1:0] r0_sh,
  input  logic [W-1:0] r0_sd,
  input  logic [W-1:0] r0_k,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [W-1:0] r1_sh,
  input  logic [W-1:0] r1_sd,
  input  logic [W-1:0] r1_k,
  output logic         o0_valid,
  input  logic         o0_ready,
  output logic [W-1:0] o0_inv_t,
  output logic         o1_valid,
  input  logic         o1_ready,
  output logic [W-1:0] o1_inv_t,
  output logic         dp_in_valid,
  output logic [W-1:0] dp_sh,
  output logic [W-1:0] dp_sd,
  output logic [W-1:0] dp_k,
  input  logic         dp_out_valid,
  input  logic [W-1:0] dp_inv_t
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [CW-1:0]     infl0_q, infl0_d, infl1_q, infl1_d;
  logic [CW-1:0]     cnt0, cnt1, credit0, credit1;
  logic              empty0, empty1;
  logic              cand0, cand1, acc0, acc1;
  logic              dp_valid_q, dp_valid_d, dp_id_q, dp_id_d;
  req_t              dp_op_q, dp_op_d;
  logic [DP_LAT-1:0] tag_vld_q, tag_vld_d, tag_id_q, tag_id_d;
  logic              tail_vld, tail_id, ret0, ret1, push0, push1, pop0, pop1;
  logic              err_q, err_d;

  // Credit covers both queued and in-flight results so the FIFO can never overflow.
  assign credit0 = CW'(FIFO_DEPTH) - cnt0 - infl0_q;
  assign credit1 = CW'(FIFO_DEPTH) - cnt1 - infl1_q;
  assign cand0   = (state_q == StRun) && (credit0 != '0);
  assign cand1   = (state_q == StRun) && (credit1 != '0);

  // last_q = 1 means port 1 won last; a port only loses to a valid, eligible, favoured rival.
  assign r0_ready = cand0 && !(cand1 && r1_valid && !last_q);
  assign r1_ready = cand1 && !(cand0 && r0_valid && last_q);
  assign acc0     = r0_valid && r0_ready;
  assign acc1     = r1_valid && r1_ready;

  assign tail_vld = tag_vld_q[DP_LAT-1];
  assign tail_id  = tag_id_q[DP_LAT-1];
  assign ret0     = tail_vld && !tail_id;
  assign ret1     = tail_vld && tail_id;
  assign push0    = dp_out_valid && ret0;
  assign push1    = dp_out_valid && ret1;
  assign pop0     = o0_valid && o0_ready;
  assign pop1     = o1_valid && o1_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && !stop) state_d = StRun;
      StRun:   if (stop) state_d = StDrain;
      StDrain: begin
        if ((infl0_q == '0) && (infl1_q == '0) && empty0 && empty1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dp_valid_d = acc0 || acc1;
    dp_id_d    = dp_id_q;
    dp_op_d    = dp_op_q;
    last_d     = last_q;
    if (acc0) begin
      dp_id_d    = 1'b0;
      dp_op_d.sh = r0_sh;
      dp_op_d.sd = r0_sd;
      dp_op_d.k  = r0_k;
      last_d     = 1'b0;
    end else if (acc1) begin
      dp_id_d    = 1'b1;
      dp_op_d.sh = r1_sh;
      dp_op_d.sd = r1_sd;
      dp_op_d.k  = r1_k;
      last_d     = 1'b1;
    end
    // Tags enter one cycle after the accept, aligned with dp_in_valid.
    tag_vld_d = (tag_vld_q << 1) | DP_LAT'(dp_valid_q);
    tag_id_d  = (tag_id_q << 1) | DP_LAT'(dp_id_q);
    infl0_d   = infl0_q + CW'(acc0) - CW'(ret0);
    infl1_d   = infl1_q + CW'(acc1) - CW'(ret1);
    err_d     = err_q || (dp_out_valid && !tail_vld);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      infl0_q    <= '0;
      infl1_q    <= '0;
      dp_valid_q <= 1'b0;
      dp_id_q    <= 1'b0;
      dp_op_q    <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      infl0_q    <= infl0_d;
      infl1_q    <= infl1_d;
      dp_valid_q <= dp_valid_d;
      dp_id_q    <= dp_id_d;
      dp_op_q    <= dp_op_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      err_q      <= err_d;
    end
  end

  tcalc_res_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (W)
  ) u_fifo0 (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push0),
    .wdata_i (dp_inv_t),
    .pop_i   (pop0),
    .rdata_o (o0_inv_t),
    .count_o (cnt0),
    .empty_o (empty0)
  );

  tcalc_res_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (W)
  ) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push1),
    .wdata_i (dp_inv_t),
    .pop_i   (pop1),
    .rdata_o (o1_inv_t),
    .count_o (cnt1),
    .empty_o (empty1)
  );

  assign o0_valid    = !empty0;
  assign o1_valid    = !empty1;
  assign busy        = (state_q != StIdle);
  assign err_orphan  = err_q;
  assign dp_in_valid = dp_valid_q;
  assign dp_sh       = dp_op_q.sh;
  assign dp_sd       = dp_op_q.sd;
  assign dp_k        = dp_op_q.k;

`ifdef TCALC_ARB_STATS_EN
  logic [15:0] stat_issue0_q, stat_issue0_d, stat_issue1_q, stat_issue1_d;
  logic [15:0] stat_stall_q, stat_stall_d;
  logic        stall;

  assign stall = (state_q == StRun) && ((r0_valid && !r0_ready) || (r1_valid && !r1_ready));

  always_comb begin
    stat_issue0_d = (acc0 && (stat_issue0_q != '1)) ? stat_issue0_q + 16'd1 : stat_issue0_q;
    stat_issue1_d = (acc1 && (stat_issue1_q != '1)) ? stat_issue1_q + 16'd1 : stat_issue1_q;
    stat_stall_d  = (stall && (stat_stall_q != '1)) ? stat_stall_q + 16'd1 : stat_stall_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issue0_q <= '0;
      stat_issue1_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issue0_q <= stat_issue0_d;
      stat_issue1_q <= stat_issue1_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issue0 = stat_issue0_q;
  assign stat_issue1 = stat_issue1_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_tcalc_arb.sv
// Directed + random bench for tcalc_arb; a transaction-level model predicts every output each cycle.
module tb_tcalc_arb;

  localparam int DP_LAT     = 6;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic        busy, err_orphan;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [11:0] r0_sh, r0_sd, r0_k, r1_sh, r1_sd, r1_k;
  logic        o0_valid, o0_ready, o1_valid, o1_ready;
  logic [11:0] o0_inv_t, o1_inv_t;
  logic        dp_in_valid, dp_out_valid;
  logic [11:0] dp_sh, dp_sd, dp_k, dp_inv_t;
`ifdef TCALC_ARB_STATS_EN
  logic [15:0] stat_issue0, stat_issue1, stat_stall;
`endif

  tcalc_arb #(
    .DP_LAT     (DP_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .busy         (busy),
    .err_orphan   (err_orphan),
`ifdef TCALC_ARB_STATS_EN
    .stat_issue0  (stat_issue0),
    .stat_issue1  (stat_issue1),
    .stat_stall   (stat_stall),
`endif
    .r0_valid     (r0_valid),
    .r0_ready     (r0_ready),
    .r0_sh        (r0_sh),
    .r0_sd        (r0_sd),
    .r0_k         (r0_k),
    .r1_valid     (r1_valid),
    .r1_ready     (r1_ready),
    .r1_sh        (r1_sh),
    .r1_sd        (r1_sd),
    .r1_k         (r1_k),
    .o0_valid     (o0_valid),
    .o0_ready     (o0_ready),
    .o0_inv_t     (o0_inv_t),
    .o1_valid     (o1_valid),
    .o1_ready     (o1_ready),
    .o1_inv_t     (o1_inv_t),
    .dp_in_valid  (dp_in_valid),
    .dp_sh        (dp_sh),
    .dp_sd        (dp_sd),
    .dp_k         (dp_k),
    .dp_out_valid (dp_out_valid),
    .dp_inv_t     (dp_inv_t)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [11:0] val;
    int          due;
  } fl_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  int          m_state;
  int          m_last;
  logic        m_err;
  logic [11:0] m_q0[$];
  logic [11:0] m_q1[$];
  fl_t         m_fl[$];
  logic        m_dpv;
  logic [11:0] m_dsh, m_dsd, m_dk;
  int          acc_cnt[2];
  int          pop_cnt[2];
  bit          g_a0, g_a1;
  int          t_ov0;

  // Datapath stand-in
  logic [DP_LAT-1:0] e_v;
  logic [11:0]       e_d[DP_LAT];
  logic              inj;
  logic [11:0]       inj_d;

  function automatic logic [11:0] golden(input logic [11:0] sh, input logic [11:0] sd,
                                         input logic [11:0] k);
    logic [11:0] t;
    t = sh * 12'd3 + (sd >> 2);
    return t ^ k;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int          infl0, infl1, cr0, cr1, nstate;
    bit          el0, el1, rdy0, rdy1, a0, a1, p0, p1, cap_v;
    logic [11:0] cap_r, g0, g1;
    logic [35:0] ops0, ops1;
    fl_t         e;
    dp_out_valid = e_v[DP_LAT-1] | inj;
    dp_inv_t     = inj ? inj_d : e_d[DP_LAT-1];
    #1;
    a0 = 0; a1 = 0; p0 = 0; p1 = 0; nstate = m_state;
    if (!rst) begin
      infl0 = 0; infl1 = 0;
      foreach (m_fl[i]) if (m_fl[i].port == 0) infl0++; else infl1++;
      cr0  = FIFO_DEPTH - m_q0.size() - infl0;
      cr1  = FIFO_DEPTH - m_q1.size() - infl1;
      el0  = (m_state == 1) && (cr0 > 0);
      el1  = (m_state == 1) && (cr1 > 0);
      // With both eligible and requesting, the port not granted last wins.
      rdy0 = el0 && !(el1 && r1_valid && m_last == 0);
      rdy1 = el1 && !(el0 && r0_valid && m_last == 1);
      chk("busy", busy, m_state != 0);
      chk("err_orphan", err_orphan, m_err);
      chk("r0_ready", r0_ready, rdy0);
      chk("r1_ready", r1_ready, rdy1);
      chk("o0_valid", o0_valid, m_q0.size() != 0);
      chk("o1_valid", o1_valid, m_q1.size() != 0);
      if (m_q0.size() != 0) chk("o0_inv_t", o0_inv_t, m_q0[0]);
      if (m_q1.size() != 0) chk("o1_inv_t", o1_inv_t, m_q1[0]);
      chk("dp_in_valid", dp_in_valid, m_dpv);
      chk("dp_ops", {dp_sh, dp_sd, dp_k}, {m_dsh, m_dsd, m_dk});
      case (m_state)
        0:       if (start && !stop) nstate = 1;
        1:       if (stop) nstate = 2;
        default: if (m_fl.size() == 0 && m_q0.size() == 0 && m_q1.size() == 0) nstate = 0;
      endcase
      a0 = r0_valid && rdy0;
      a1 = r1_valid && rdy1;
      p0 = o0_ready && (m_q0.size() != 0);
      p1 = o1_ready && (m_q1.size() != 0);
    end
    if (o0_valid === 1'b1 && t_ov0 < 0) t_ov0 = cyc;
    cap_v = dp_in_valid;
    cap_r = golden(dp_sh, dp_sd, dp_k);
    ops0  = {r0_sh, r0_sd, r0_k};
    ops1  = {r1_sh, r1_sd, r1_k};
    g0    = golden(r0_sh, r0_sd, r0_k);
    g1    = golden(r1_sh, r1_sd, r1_k);
    g_a0  = a0;
    g_a1  = a1;
    @(posedge clk);
    #1;
    if (rst) begin
      m_state = 0; m_last = 1; m_err = 0; m_dpv = 0;
      m_dsh = '0; m_dsd = '0; m_dk = '0;
      m_q0.delete(); m_q1.delete(); m_fl.delete();
      e_v = '0;
      for (int i = 0; i < DP_LAT; i++) e_d[i] = '0;
    end else begin
      for (int i = DP_LAT - 1; i > 0; i--) e_d[i] = e_d[i-1];
      e_d[0] = cap_r;
      e_v    = {e_v[DP_LAT-2:0], cap_v};
      if (p0) begin void'(m_q0.pop_front()); pop_cnt[0]++; end
      if (p1) begin void'(m_q1.pop_front()); pop_cnt[1]++; end
      while (m_fl.size() != 0 && m_fl[0].due == cyc) begin
        if (m_fl[0].port == 0) m_q0.push_back(m_fl[0].val);
        else m_q1.push_back(m_fl[0].val);
        void'(m_fl.pop_front());
      end
      if (inj) m_err = 1'b1;
      m_dpv = a0 || a1;
      if (a0 || a1) begin
        e.port = a0 ? 0 : 1;
        e.val  = a0 ? g0 : g1;
        e.due  = cyc + 1 + DP_LAT;
        m_fl.push_back(e);
        {m_dsh, m_dsd, m_dk} = a0 ? ops0 : ops1;
        acc_cnt[e.port]++;
        m_last = e.port;
      end
      m_state = nstate;
    end
    cyc++;
  endtask

  task automatic rnd_ops();
    r0_sh = 12'($urandom); r0_sd = 12'($urandom); r0_k = 12'($urandom);
    r1_sh = 12'($urandom); r1_sd = 12'($urandom); r1_k = 12'($urandom);
  endtask

  initial begin
    int  b0, b1, prev, t_acc, p0s, p1s;
    bit  done, both;
    rst = 1; start = 0; stop = 0; inj = 0; inj_d = '0;
    r0_valid = 0; r1_valid = 0; o0_ready = 0; o1_ready = 0;
    r0_sh = '0; r0_sd = '0; r0_k = '0; r1_sh = '0; r1_sd = '0; r1_k = '0;
    dp_out_valid = 0; dp_inv_t = '0; e_v = '0;
    for (int i = 0; i < DP_LAT; i++) e_d[i] = '0;
    m_state = 0; m_last = 1; m_err = 0; m_dpv = 0; m_dsh = '0; m_dsd = '0; m_dk = '0;
    acc_cnt = '{0, 0}; pop_cnt = '{0, 0}; t_ov0 = -1;
    step(); step();
    rst = 0;
    step();

    // Single request: latency and golden value
    start = 1; step(); start = 0;
    r0_valid = 1; r0_sh = 12'h400; r0_sd = 12'h800; r0_k = 12'h140;
    t_acc = -1;
    for (int i = 0; i < 5 && t_acc < 0; i++) begin
      step();
      if (g_a0) t_acc = cyc - 1;
    end
    r0_valid = 0;
    chk("req021_accept", t_acc >= 0, 1'b1);
    chk("req021_dp_in_valid", dp_in_valid, 1'b1);
    t_ov0 = -1;
    for (int i = 0; i < 20 && t_ov0 < 0; i++) step();
    chk("req021_latency", t_ov0 - t_acc, DP_LAT + 2);
    chk("req021_inv_t", o0_inv_t, 12'hF40);
    o0_ready = 1; step(); step();

    // Continuous traffic on both ports: strict alternation, 100 results each
    rst = 1; step(); rst = 0;
    start = 1; step(); start = 0;
    o0_ready = 1; o1_ready = 1;
    b0 = acc_cnt[0]; b1 = acc_cnt[1]; p0s = pop_cnt[0]; p1s = pop_cnt[1];
    prev = 1; done = 0;
    rnd_ops();
    for (int i = 0; i < 4000 && !done; i++) begin
      r0_valid = (acc_cnt[0] - b0) < 100;
      r1_valid = (acc_cnt[1] - b1) < 100;
      both = r0_valid && r1_valid;
      step();
      if (g_a0 || g_a1) begin
        if (both) chk("req022_alternate", g_a1 ? 1 : 0, 1 - prev);
        prev = g_a1 ? 1 : 0;
        rnd_ops();
      end
      done = (pop_cnt[0] - p0s >= 100) && (pop_cnt[1] - p1s >= 100);
    end
    r0_valid = 0; r1_valid = 0;
    chk("req022_pops0", pop_cnt[0] - p0s, 100);
    chk("req022_pops1", pop_cnt[1] - p1s, 100);

    // Port 0 backpressured at its output: stalls after FIFO_DEPTH accepts, port 1 keeps going
    o0_ready = 0; o1_ready = 1;
    r0_valid = 1; r1_valid = 1;
    b0 = acc_cnt[0]; b1 = acc_cnt[1];
    for (int i = 0; i < 60; i++) begin
      step();
      if (g_a0 || g_a1) rnd_ops();
    end
    chk("req023_port0_accepts", acc_cnt[0] - b0, FIFO_DEPTH);
    chk("req023_port1_flows", (acc_cnt[1] - b1) > 10, 1'b1);
    o0_ready = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (g_a0 || g_a1) rnd_ops();
    end
    r0_valid = 0; r1_valid = 0;
    for (int i = 0; i < 20; i++) step();
    chk("req023_no_loss0", pop_cnt[0], acc_cnt[0]);
    chk("req023_no_loss1", pop_cnt[1], acc_cnt[1]);

    // Stop with three in flight: drain then idle
    o0_ready = 0;
    b0 = acc_cnt[0]; p0s = pop_cnt[0];
    r0_valid = 1;
    for (int i = 0; i < 10 && (acc_cnt[0] - b0) < 3; i++) begin
      step();
      if (g_a0) rnd_ops();
    end
    r0_valid = 0; stop = 1; step(); stop = 0;
    r0_valid = 1; r1_valid = 1;
    for (int i = 0; i < 15; i++) step();
    chk("req024_busy_held", busy, 1'b1);
    chk("req024_no_accept", acc_cnt[0] - b0, 3);
    o0_ready = 1;
    for (int i = 0; i < 20 && busy !== 1'b0; i++) step();
    r0_valid = 0; r1_valid = 0;
    chk("req024_popped", pop_cnt[0] - p0s, 3);
    chk("req024_idle", busy, 1'b0);
    step();

    // Orphan result while idle
    inj = 1; inj_d = 12'($urandom); step(); inj = 0;
    for (int i = 0; i < 3; i++) step();
    chk("req025_err_sticky", err_orphan, 1'b1);
    chk("req025_no_write", o0_valid | o1_valid, 1'b0);
    start = 1; step(); start = 0;
    r1_valid = 1; rnd_ops(); step(); r1_valid = 0;
    for (int i = 0; i < 12; i++) step();
    chk("req025_err_until_rst", err_orphan, 1'b1);

    // Reset two cycles after an accept
    r0_valid = 1; rnd_ops();
    t_acc = -1;
    for (int i = 0; i < 5 && t_acc < 0; i++) begin
      step();
      if (g_a0) t_acc = cyc - 1;
    end
    r0_valid = 0;
    step();
    rst = 1; step(); rst = 0;
    chk("req026_busy", busy, 1'b0);
    chk("req026_dp_in_valid", dp_in_valid, 1'b0);
    chk("req026_err", err_orphan, 1'b0);
    start = 1; step(); start = 0;
    for (int i = 0; i < 20; i++) step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r0_valid = 1'($urandom_range(0, 1));
      r1_valid = 1'($urandom_range(0, 1));
      o0_ready = ($urandom_range(0, 3) != 0);
      o1_ready = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 63) == 0);
      rnd_ops();
      step();
    end
    r0_valid = 0; r1_valid = 0; start = 0; stop = 0; o0_ready = 1; o1_ready = 1;
    for (int i = 0; i < 20; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
